// File: rtl/dff_piso_serializer.sv
// Parallel-in/serial-out readout stage: captures a WIDTH-bit word on a valid/ready
// load port and streams it out one bit per accepted beat with complementary outputs.
module dff_piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_out_n,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   shift_r, shift_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               load_ready_r, load_ready_s;
    logic               ser_valid_r, ser_valid_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               load_acc_s;
    logic               beat_acc_s;

    // Move the word one place toward the output end, filling with zero.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {v[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, v[WIDTH-1:1]};
        end
        return r;
    endfunction

    assign load_acc_s = load_valid && load_ready_r;
    assign beat_acc_s = ser_valid_r && ser_ready;

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_acc_s) begin
                    shift_s = data_in;
                    cnt_s   = CNT_W'(WIDTH - 1);
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (beat_acc_s) begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        shift_s = shift_once(shift_r);
                        cnt_s   = cnt_r - CNT_W'(1);
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Handshake outputs track the upcoming state so they change with it.
        load_ready_s = (state_s == ST_IDLE);
        ser_valid_s  = (state_s == ST_SHIFT);
        busy_s       = (state_s == ST_SHIFT);
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            shift_r      <= {WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            load_ready_r <= 1'b0;
            ser_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            cnt_r        <= cnt_s;
            load_ready_r <= load_ready_s;
            ser_valid_r  <= ser_valid_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign ser_out    = MSB_FIRST ? shift_r[WIDTH-1] : shift_r[0];
    assign ser_out_n  = ~ser_out;
    assign load_ready = load_ready_r;
    assign ser_valid  = ser_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_dff_piso_serializer.sv
// Scoreboard bench for dff_piso_serializer: one MSB-first and one LSB-first instance
// share stimulus; monitors pop expected bits whenever a beat is accepted.
module tb_dff_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic [7:0] data_in;
    logic       ser_ready;

    logic m_load_ready, m_ser_valid, m_ser_out, m_ser_out_n, m_busy, m_done;
    logic l_load_ready, l_ser_valid, l_ser_out, l_ser_out_n, l_busy, l_done;

    int checks = 0;
    int errors = 0;
    int m_done_cnt = 0;
    int l_done_cnt = 0;
    logic m_q[$];
    logic l_q[$];

    dff_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(m_load_ready),
        .data_in(data_in), .ser_valid(m_ser_valid), .ser_ready(ser_ready),
        .ser_out(m_ser_out), .ser_out_n(m_ser_out_n), .busy(m_busy), .done(m_done)
    );

    dff_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(l_load_ready),
        .data_in(data_in), .ser_valid(l_ser_valid), .ser_ready(ser_ready),
        .ser_out(l_ser_out), .ser_out_n(l_ser_out_n), .busy(l_busy), .done(l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
        end
    endtask

    // Streams are written in output order, first bit in position 7.
    task automatic push_exp(input logic [7:0] m_stream, input logic [7:0] l_stream);
        for (int i = 7; i >= 0; i--) begin
            m_q.push_back(m_stream[i]);
            l_q.push_back(l_stream[i]);
        end
    endtask

    task automatic load_word(input logic [7:0] w, input logic [7:0] m_stream,
                             input logic [7:0] l_stream);
        int n;
        n = 0;
        while (!m_load_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL load_ready_timeout actual=0 expected=1");
        end
        push_exp(m_stream, l_stream);
        load_valid = 1'b1;
        data_in    = w;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic chk_both(input string nm, input logic m_act, input logic l_act,
                            input logic exp);
        chk({"m_", nm}, m_act, exp);
        chk({"l_", nm}, l_act, exp);
    endtask

    // MSB-first monitor: complement, done exclusivity, scoreboard pop on accepted beats.
    always @(negedge clk) begin
        logic e;
        chk("m_ser_out_n", m_ser_out_n, ~m_ser_out);
        if (m_done === 1'b1) begin
            m_done_cnt++;
            chk("m_done_with_valid", m_ser_valid, 1'b0);
        end
        if (m_ser_valid === 1'b1 && ser_ready === 1'b1) begin
            if (m_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m_unexpected_bit actual=%0b expected=none", m_ser_out);
            end else begin
                e = m_q.pop_front();
                chk("m_bit", m_ser_out, e);
            end
        end
    end

    // LSB-first monitor, same checks.
    always @(negedge clk) begin
        logic e;
        chk("l_ser_out_n", l_ser_out_n, ~l_ser_out);
        if (l_done === 1'b1) begin
            l_done_cnt++;
            chk("l_done_with_valid", l_ser_valid, 1'b0);
        end
        if (l_ser_valid === 1'b1 && ser_ready === 1'b1) begin
            if (l_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL l_unexpected_bit actual=%0b expected=none", l_ser_out);
            end else begin
                e = l_q.pop_front();
                chk("l_bit", l_ser_out, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int saved_m;
        int saved_l;
        rst_n      = 1'b1;
        load_valid = 1'b0;
        data_in    = 8'h00;
        ser_ready  = 1'b1;

        // Asynchronous reset assertion mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        chk_both("rst_ser_out", m_ser_out, l_ser_out, 1'b0);
        chk_both("rst_ser_out_n", m_ser_out_n, l_ser_out_n, 1'b1);
        chk_both("rst_ser_valid", m_ser_valid, l_ser_valid, 1'b0);
        chk_both("rst_load_ready", m_load_ready, l_load_ready, 1'b0);
        chk_both("rst_done", m_done, l_done, 1'b0);
        chk_both("rst_busy", m_busy, l_busy, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk_both("rel_load_ready_low", m_load_ready, l_load_ready, 1'b0);
        @(posedge clk);
        #1;
        chk_both("rel_load_ready_high", m_load_ready, l_load_ready, 1'b1);

        // 0xC4 unstalled: done and load_ready return together after beat 8.
        load_word(8'hC4, 8'b1100_0100, 8'b0010_0011);
        chk_both("c4_busy", m_busy, l_busy, 1'b1);
        chk_both("c4_load_ready_low", m_load_ready, l_load_ready, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        chk_both("c4_valid_before_last", m_ser_valid, l_ser_valid, 1'b1);
        chk_both("c4_done_early", m_done, l_done, 1'b0);
        @(posedge clk);
        #1;
        chk_both("c4_done", m_done, l_done, 1'b1);
        chk_both("c4_load_ready_back", m_load_ready, l_load_ready, 1'b1);
        chk_both("c4_valid_off", m_ser_valid, l_ser_valid, 1'b0);
        @(posedge clk);
        #1;
        chk_both("c4_done_single", m_done, l_done, 1'b0);

        // 0xF0 with a 3-cycle stall after beat 2; done lands 3 cycles late.
        load_word(8'hF0, 8'b1111_0000, 8'b0000_1111);
        repeat (2) @(posedge clk);
        #1;
        ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("m_stall_hold", m_ser_out, 1'b1);
            chk("l_stall_hold", l_ser_out, 1'b0);
            chk_both("stall_valid", m_ser_valid, l_ser_valid, 1'b1);
            @(posedge clk);
        end
        #1;
        ser_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_both("f0_done_early", m_done, l_done, 1'b0);
        @(posedge clk);
        #1;
        chk_both("f0_done_late", m_done, l_done, 1'b1);

        // 0xAA with 0x55 offered on load during beat 3; it must be ignored.
        @(posedge clk);
        #1;
        load_word(8'hAA, 8'b1010_1010, 8'b0101_0101);
        @(posedge clk);
        #1;
        load_valid = 1'b1;
        data_in    = 8'h55;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        data_in    = 8'h00;
        repeat (6) @(posedge clk);
        #1;
        chk_both("aa_done", m_done, l_done, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_both("aa_no_capture", m_ser_valid, l_ser_valid, 1'b0);

        // 0xFF interrupted by reset after beat 4: no done, then a clean 0x0F.
        load_word(8'hFF, 8'b1111_1111, 8'b1111_1111);
        saved_m = m_done_cnt;
        saved_l = l_done_cnt;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        m_q.delete();
        l_q.delete();
        chk_both("mid_rst_ser_out", m_ser_out, l_ser_out, 1'b0);
        chk_both("mid_rst_ser_out_n", m_ser_out_n, l_ser_out_n, 1'b1);
        chk_both("mid_rst_valid", m_ser_valid, l_ser_valid, 1'b0);
        chk_both("mid_rst_busy", m_busy, l_busy, 1'b0);
        chk_both("mid_rst_load_ready", m_load_ready, l_load_ready, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        load_word(8'h0F, 8'b0000_1111, 8'b1111_0000);
        repeat (9) @(posedge clk);
        #1;
        chk("m_no_done_on_reset", (m_done_cnt == saved_m + 1) ? 1'b1 : 1'b0, 1'b1);
        chk("l_no_done_on_reset", (l_done_cnt == saved_l + 1) ? 1'b1 : 1'b0, 1'b1);

        // Four completed words in total; every expected bit consumed.
        chk("m_done_count", (m_done_cnt == 4) ? 1'b1 : 1'b0, 1'b1);
        chk("l_done_count", (l_done_cnt == 4) ? 1'b1 : 1'b0, 1'b1);
        chk("m_queue_empty", (m_q.size() == 0) ? 1'b1 : 1'b0, 1'b1);
        chk("l_queue_empty", (l_q.size() == 0) ? 1'b1 : 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
